// File: rtl/gpr_rr_pkg.sv
// Shared definitions for the round-robin register-bank controller:
// controller state encoding, default widths and the pointer-advance helper.
package gpr_rr_pkg;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Round-robin successor of requester r among n_req requesters.
  function automatic int unsigned next_ptr(input int unsigned r, input int unsigned n_req);
    if (r + 32'd1 >= n_req) begin
      next_ptr = 32'd0;
    end else begin
      next_ptr = r + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the
// priority pointer and advances the pointer past each granted requester.
module rr_arbiter
  import gpr_rr_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int ID_WIDTH = DEF_ID_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_REQ-1:0]    i_valid,
  input  logic                i_en,
  output logic [N_REQ-1:0]    o_grant,
  output logic [ID_WIDTH-1:0] o_grant_id
);

  logic [ID_WIDTH-1:0] ptr_r;
  logic                found_s;

  // Search ptr, ptr+1, ... (mod N_REQ) for the first valid requester.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    found_s    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (i_en && !found_s && i_valid[r] && (r == ((int'(ptr_r) + k) % N_REQ))) begin
          o_grant[r] = 1'b1;
          o_grant_id = ID_WIDTH'(r);
          found_s    = 1'b1;
        end else begin
          found_s    = found_s;
        end
      end
    end
  end

  // Move priority past the granted requester; hold when nothing fires.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= ID_WIDTH'(next_ptr(32'(o_grant_id), N_REQ));
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/gpr_rr_ctrl.sv
// Register-bank controller: self-initialises the bank to k+1 after reset,
// then serves one round-robin-arbitrated read or write per cycle and returns
// a tagged response on the following cycle.
module gpr_rr_ctrl
  import gpr_rr_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ-1:0]            i_req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic                        o_rsp_valid,
  output logic [ID_WIDTH-1:0]         o_rsp_id,
  output logic                        o_rsp_we,
  output logic [DATA_WIDTH-1:0]       o_rsp_data,
  output logic                        o_init_done
);

  localparam int ADDR_COUNT = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_COUNT - 1);

  state_e                  state_r;
  logic [ADDR_WIDTH-1:0]   init_cnt_r;
  logic                    init_done_r;
  logic [DATA_WIDTH-1:0]   bank_r [ADDR_COUNT];

  logic                    rsp_valid_r;
  logic [ID_WIDTH-1:0]     rsp_id_r;
  logic                    rsp_we_r;
  logic [DATA_WIDTH-1:0]   rsp_data_r;

  logic                    run_s;
  logic                    fire_s;
  logic [N_REQ-1:0]        grant_s;
  logic [ID_WIDTH-1:0]     grant_id_s;
  logic                    sel_we_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic [DATA_WIDTH-1:0]   init_value_s;

  assign run_s        = (state_r == ST_RUN);
  assign fire_s       = |grant_s;
  assign init_value_s = DATA_WIDTH'(init_cnt_r) + DATA_WIDTH'(1'b1);

  rr_arbiter #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_req_valid),
    .i_en       (run_s),
    .o_grant    (grant_s),
    .o_grant_id (grant_id_s)
  );

  // Route the granted requester's command fields to the bank port.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant_s[r]) begin
        sel_we_s    = i_req_we[r];
        sel_addr_s  = i_req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_s = i_req_wdata[r*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_we_s    = sel_we_s;
      end
    end
  end

  // Controller FSM: walk the init counter once, then stay in RUN until reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_INIT;
      init_cnt_r  <= '0;
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (init_cnt_r == LAST_ADDR) begin
            init_cnt_r  <= '0;
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end else begin
            init_cnt_r  <= init_cnt_r + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r     <= ST_INIT;
          init_cnt_r  <= '0;
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Bank storage: filled by the init walk, then written by granted writes.
  always_ff @(posedge i_clk) begin
    if (!run_s) begin
      bank_r[init_cnt_r] <= init_value_s;
    end else if (fire_s && sel_we_s) begin
      bank_r[sel_addr_s] <= sel_wdata_s;
    end else begin
      bank_r[sel_addr_s] <= bank_r[sel_addr_s];
    end
  end

  // Response registers: one-cycle pulse tagged with the granted requester.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_we_r    <= 1'b0;
      rsp_data_r  <= '0;
    end else begin
      rsp_valid_r <= fire_s;
      if (fire_s) begin
        rsp_id_r   <= grant_id_s;
        rsp_we_r   <= sel_we_s;
        rsp_data_r <= sel_we_s ? sel_wdata_s : bank_r[sel_addr_s];
      end else begin
        rsp_id_r   <= rsp_id_r;
        rsp_we_r   <= rsp_we_r;
        rsp_data_r <= rsp_data_r;
      end
    end
  end

  assign o_req_ready = grant_s;
  assign o_rsp_valid = rsp_valid_r;
  assign o_rsp_id    = rsp_id_r;
  assign o_rsp_we    = rsp_we_r;
  assign o_rsp_data  = rsp_data_r;
  assign o_init_done = init_done_r;

endmodule

// File: tb/tb_gpr_rr_ctrl.sv
// Bench for gpr_rr_ctrl: a transaction-level model (bank array, pointer,
// init edge count) is compared to the DUT every falling edge, and directed
// sequences pin the model with hand-computed values.
module tb_gpr_rr_ctrl;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int AC = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic            rsp_we;
  logic [DW-1:0]   rsp_data;
  logic            init_done;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit sticky   = 1'b0;

  // model state
  bit            m_done = 1'b0;
  int            m_edges = 0;
  int            m_ptr = 0;
  logic [DW-1:0] m_bank [AC];
  bit            m_rsp_valid = 1'b0;
  int            m_rsp_id = 0;
  bit            m_rsp_we = 1'b0;
  logic [DW-1:0] m_rsp_data = '0;
  logic [N-1:0]  fire_mask = '0;

  gpr_rr_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_we    (rsp_we),
    .o_rsp_data  (rsp_data),
    .o_init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester the model would grant now, -1 if none.
  function automatic int pick();
    int r;
    if (!m_done) return -1;
    for (int k = 0; k < N; k++) begin
      r = (m_ptr + k) % N;
      if (req_valid[r[1:0]]) return r;
    end
    return -1;
  endfunction

  // Transaction-level model of one clock edge.
  always @(posedge clk or posedge rst) begin
    int g;
    logic [AW-1:0] a;
    if (rst) begin
      m_done = 1'b0; m_edges = 0; m_ptr = 0;
      m_rsp_valid = 1'b0; m_rsp_id = 0; m_rsp_we = 1'b0; m_rsp_data = '0;
      fire_mask = '0;
    end else if (!m_done) begin
      m_bank[m_edges[1:0]] = DW'(m_edges + 1);
      m_edges++;
      if (m_edges == AC) m_done = 1'b1;
      m_rsp_valid = 1'b0;
      fire_mask = '0;
    end else begin
      g = pick();
      if (g < 0) begin
        m_rsp_valid = 1'b0;
        fire_mask = '0;
      end else begin
        a = req_addr[g*AW +: AW];
        m_rsp_valid = 1'b1;
        m_rsp_id = g;
        m_rsp_we = req_we[g[1:0]];
        if (m_rsp_we) begin
          m_rsp_data = req_wdata[g*DW +: DW];
          m_bank[a] = m_rsp_data;
        end else begin
          m_rsp_data = m_bank[a];
        end
        m_ptr = (g + 1) % N;
        fire_mask = N'(1) << g;
      end
    end
  end

  // Requesters drop valid once their transfer fired (unless held sticky).
  always @(posedge clk) begin
    #1;
    if (!sticky) req_valid = req_valid & ~fire_mask;
  end

  // Compare DUT outputs with the model every falling edge.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_ready;
    g = pick();
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    check("ready", 64'(req_ready), 64'(exp_ready));
    check("init_done", 64'(init_done), 64'(m_done));
    check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
    if (m_rsp_valid) begin
      check("rsp_id", 64'(rsp_id), 64'(m_rsp_id));
      check("rsp_we", 64'(rsp_we), 64'(m_rsp_we));
      check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
    end
  end

  task automatic issue(input int r, input bit we, input int addr, input logic [DW-1:0] d);
    req_we[r[1:0]] = we;
    req_addr[r*AW +: AW] = addr[1:0];
    req_wdata[r*DW +: DW] = d;
    req_valid[r[1:0]] = 1'b1;
  endtask

  task automatic wait_rsp(input int r, input logic [DW-1:0] exp, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_id == r[IW-1:0]) begin
        seen = 1'b1;
        check(name, 64'(rsp_data), 64'(exp));
      end
    end
    if (!seen) begin
      chk_cnt++;
      $display("FAIL %s: no response for requester %0d within 20 cycles", name, r);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);

    // all four requesters read their own address, held through init
    sticky = 1'b1;
    for (int r = 0; r < N; r++) issue(r, 1'b0, r, '0);
    #9 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("init_3_edges", 64'(init_done), 64'd0);
    check("ready_in_init", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("init_4_edges", 64'(init_done), 64'd1);
    check("first_grant", 64'(req_ready), 64'h1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_valid", 64'(rsp_valid), 64'd1);
      check("rr_id", 64'(rsp_id), 64'(k % 4));
      check("rr_data", 64'(rsp_data), 64'((k % 4) + 1));
    end
    @(posedge clk); #2;
    sticky = 1'b0;
    req_valid = '0;

    // read-after-write across consecutive grants
    @(posedge clk); #2;
    issue(1, 1'b1, 2, 32'hDEADBEEF);
    @(posedge clk); #2;
    issue(3, 1'b0, 2, '0);
    @(negedge clk);
    check("raw_wr_id", 64'(rsp_id), 64'd1);
    check("raw_wr_we", 64'(rsp_we), 64'd1);
    check("raw_wr_data", 64'(rsp_data), 64'hDEADBEEF);
    @(negedge clk);
    check("raw_rd_id", 64'(rsp_id), 64'd3);
    check("raw_rd_we", 64'(rsp_we), 64'd0);
    check("raw_rd_data", 64'(rsp_data), 64'hDEADBEEF);

    // move pointer to 1, then contend requesters 0 and 2
    @(posedge clk); #2;
    issue(0, 1'b0, 0, '0);
    @(posedge clk); #2;
    issue(0, 1'b0, 0, '0);
    issue(2, 1'b0, 1, '0);
    @(negedge clk);
    check("ptr1_grant2", 64'(req_ready), 64'h4);
    @(negedge clk);
    check("ptr1_rsp2", 64'(rsp_id), 64'd2);
    check("ptr1_rsp2_data", 64'(rsp_data), 64'd2);
    check("ptr1_grant0", 64'(req_ready), 64'h1);
    @(negedge clk);
    check("ptr1_rsp0", 64'(rsp_id), 64'd0);
    @(posedge clk); #2;
    issue(0, 1'b0, 3, '0);
    issue(1, 1'b0, 3, '0);
    @(negedge clk);
    check("ptr_back_at_1", 64'(req_ready), 64'h2);
    repeat (4) @(posedge clk);

    // reset while a response is valid
    #2;
    issue(2, 1'b0, 2, '0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", 64'(rsp_valid), 64'd1);
    check("pre_rst_data", 64'(rsp_data), 64'hDEADBEEF);
    #1;
    rst = 1'b1;
    req_valid = '0;
    #1;
    check("async_rsp_valid", 64'(rsp_valid), 64'd0);
    check("async_rsp_data", 64'(rsp_data), 64'd0);
    check("async_init_done", 64'(init_done), 64'd0);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reinit_3_edges", 64'(init_done), 64'd0);
    @(negedge clk);
    check("reinit_4_edges", 64'(init_done), 64'd1);
    for (int a = 0; a < AC; a++) begin
      @(posedge clk); #2;
      issue(a, 1'b0, a, '0);
      wait_rsp(a, DW'(a + 1), "reinit_read");
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/gpr_rr_ctrl.md
Name: gpr_rr_ctrl

Overview:
- Controller owning a small general-purpose register bank (ADDR_COUNT x DATA_WIDTH), shared between N_REQ requesters.
- After reset, initialises the bank (entry k = k+1) with an internal counter.
- Then grants one read or write per cycle using round-robin arbitration.
- Returns a tagged response one cycle after each grant. Sits between pipeline clients and the shared storage.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 2, bank address width.
- ADDR_COUNT, 1 << ADDR_WIDTH, number of entries (derived; do not override).
- DATA_WIDTH, 32, entry width.
- ID_WIDTH, 2, requester index width (must satisfy 2**ID_WIDTH >= N_REQ).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  N_REQ  per-requester request valid.
- i_req_we  in  N_REQ  per-requester write enable (1 = write, 0 = read).
- i_req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester r at [r*ADDR_WIDTH +: ADDR_WIDTH].
- i_req_wdata  in  N_REQ*DATA_WIDTH  packed write data; same packing.
- o_req_ready  out  N_REQ  one-hot grant (combinational).
- o_rsp_valid  out  1  response valid, single-cycle pulse.
- o_rsp_id  out  ID_WIDTH  requester index of the response.
- o_rsp_we  out  1  1 = write acknowledge, 0 = read data.
- o_rsp_data  out  DATA_WIDTH  read data, or the written data for writes.
- o_init_done  out  1  high once the bank is initialised.

Behaviour:
- Reset (async, i_rst=1):
  - state=ST_INIT, init counter=0, priority pointer=0.
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_we=0, o_rsp_data=0, o_init_done=0, o_req_ready=0.
  - Bank contents are not reset; ST_INIT overwrites them.
- ST_INIT:
  - Each cycle writes bank[cnt] = cnt+1, zero-extended to DATA_WIDTH.
  - When cnt == ADDR_COUNT-1: cnt wraps to 0, next state ST_RUN, o_init_done <= 1.
  - Takes exactly ADDR_COUNT cycles after the first clock edge following reset release.
  - o_req_ready = 0 throughout; requests are held off, not dropped.
- ST_RUN (terminal until reset):
  - Grant = first r with i_req_valid[r]=1, searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - o_req_ready is one-hot on the granted r; all zeros if no request is valid.
  - Transfer fires when valid & ready. Pointer then updates to (r+1) mod N_REQ; unchanged if nothing fires.
- Latency:
  - Response registers update on the edge after the grant cycle: o_rsp_valid=1, o_rsp_id=r, o_rsp_we=i_req_we[r].
  - Read: o_rsp_data = bank[addr] as it was before that edge.
  - Write: bank[addr] <= wdata at that edge, and o_rsp_data = wdata.
  - o_rsp_valid drops the following cycle unless another grant fired.
  - Throughput is one transfer per cycle, back-to-back.
- Read-after-write:
  - Write granted in cycle t, read of the same address in cycle t+1: the read returns the new data.
  - There is never a same-cycle hazard, because only one transfer fires per cycle.
- Requester rules:
  - Valid, we, addr and wdata must stay stable until ready is seen; a requester may not retract valid.
  - Fairness: a continuously valid requester is granted within N_REQ cycles.
- Reset mid-operation: an in-flight response is dropped, o_rsp_valid clears immediately, and ST_INIT reruns in full.
- No response backpressure: consumers must accept o_rsp_* every cycle.

Decomposition:
- Package gpr_rr_pkg:
  - state localparams ST_INIT=1'b0, ST_RUN=1'b1;
  - default widths;
  - a function next_ptr(r) implementing (r+1) mod N_REQ.
- Sub-module rr_arbiter (N_REQ):
  - inputs i_clk, i_rst, i_valid, i_en, where i_en is 0 during ST_INIT;
  - outputs o_grant (one-hot) and o_grant_id;
  - owns the pointer register.
- The top holds the init counter, FSM, bank array and response registers.

Test Plan:
- Reset release, no requests -> o_init_done rises after exactly 4 cycles; reads then return 1,2,3,4 for addresses 0..3.
- All 4 requesters reading continuously from reset -> grant order 0,1,2,3,0,... and o_rsp_id follows one cycle later, one per cycle.
- Req1 writes 0xDEADBEEF to addr 2 in cycle t, req3 reads addr 2 in cycle t+1 -> ack {id=1, we=1, data=DEADBEEF}, then {id=3, we=0, data=DEADBEEF}.
- Req0 and req2 valid with ptr=1 -> req2 granted first, then req0; ptr ends at 1.
- Requests asserted during ST_INIT -> ready stays 0 and no response; first grant occurs in the first ST_RUN cycle.
- i_rst pulsed while o_rsp_valid=1 -> outputs clear asynchronously, ST_INIT reruns and the bank is re-initialised to 1..4.
